// File: rtl/tt_encoder_pkg.sv
// Shared types and constants for the registered 4-to-2 priority encoder.
package tt_encoder_pkg;

  localparam int CODE_W = 2;

  // uo_out field positions
  localparam int OUT_CODE_LSB = 0;
  localparam int OUT_VALID    = 2;
  localparam int OUT_STROBE   = 3;
  localparam int OUT_MULTI    = 4;
  localparam int OUT_CNT_LSB  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic              none;
    logic [CODE_W-1:0] code;
    logic              multi;
  } cand_t;

  localparam cand_t CAND_NONE = 4'b1000;

  // True when two or more bits of an active-high request vector are set.
  function automatic logic multi_hot(input logic [3:0] req);
    return (req & (req - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/sync_bus.sv
// Multi-bit synchronizer chain, WIDTH bits by STAGES flops, with a reset value.
module sync_bus
  import tt_encoder_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/tt_um_islam_ihfaz_4_2_encoder.sv
// Debounced, registered 4-to-2 priority encoder (TinyTapeout top).
// Optional LOOPBACK_DECODE_EN drives a registered active-low re-decode on uio[3:0].
module tt_um_islam_ihfaz_4_2_encoder
  import tt_encoder_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CNT_W = 3;
  localparam int SC_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] STAB_MAX = SC_W'(STABLE_CYCLES - 1);

  logic [4:0]        sync_q;
  cand_t             cand, prev_cand;
  logic [SC_W-1:0]   stab_cnt, stab_next;
  logic              stable;
  state_t            state, state_next;
  logic              commit, release_c;
  logic [CODE_W-1:0] code_q;
  logic              valid_q, strobe_q, multi_q;
  logic [CNT_W-1:0]  evt_cnt;
  logic              unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:5]};

  sync_bus #(
    .WIDTH  (5),
    .STAGES (SYNC_STAGES),
    .RST_VAL(5'h1F)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ui_in[4:0]),
    .q    (sync_q)
  );

  always_comb begin
    cand = CAND_NONE;
    if (!sync_q[4] && sync_q[3:0] != 4'hF) begin
      cand.none = 1'b0;
      if (!sync_q[3])      cand.code = 2'd3;
      else if (!sync_q[2]) cand.code = 2'd2;
      else if (!sync_q[1]) cand.code = 2'd1;
      else                 cand.code = 2'd0;
      cand.multi = multi_hot(~sync_q[3:0]);
    end
  end

  // Stability is judged on the count this edge will load, so the commit
  // lands on the same edge the counter reaches STAB_MAX.
  always_comb begin
    if (cand != prev_cand)       stab_next = '0;
    else if (stab_cnt == STAB_MAX) stab_next = stab_cnt;
    else                         stab_next = stab_cnt + 1'b1;
    stable = (stab_next == STAB_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    release_c  = 1'b0;
    case (state)
      IDLE: begin
        if (!cand.none) begin
          if (stable) begin
            commit     = 1'b1;
            state_next = HOLD;
          end else begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        if (cand.none) begin
          state_next = IDLE;
        end else if (stable) begin
          commit     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (stable) begin
          if (cand.none) begin
            release_c  = 1'b1;
            state_next = IDLE;
          end else if (cand.code != code_q || cand.multi != multi_q) begin
            commit = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cand <= CAND_NONE;
      stab_cnt  <= '0;
      code_q    <= '0;
      multi_q   <= 1'b0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      prev_cand <= cand;
      stab_cnt  <= stab_next;
      strobe_q  <= commit;
      if (commit) begin
        code_q  <= cand.code;
        multi_q <= cand.multi;
        valid_q <= 1'b1;
        evt_cnt <= evt_cnt + 1'b1;
      end else if (release_c) begin
        code_q  <= '0;
        multi_q <= 1'b0;
        valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    uo_out = '0;
    uo_out[OUT_CODE_LSB +: CODE_W] = code_q;
    uo_out[OUT_VALID]              = valid_q;
    uo_out[OUT_STROBE]             = strobe_q;
    uo_out[OUT_MULTI]              = multi_q;
    uo_out[OUT_CNT_LSB +: CNT_W]   = evt_cnt;
  end

`ifdef LOOPBACK_DECODE_EN
  logic [3:0] loop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         loop_q <= 4'hF;
    else if (commit)    loop_q <= ~(4'b0001 << cand.code);
    else if (release_c) loop_q <= 4'hF;
  end

  assign uio_out = {4'b0000, loop_q};
  assign uio_oe  = 8'h0F;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_tt_um_islam_ihfaz_4_2_encoder.sv
// Self-checking bench: directed scenarios plus randomized holds against a behavioural model.
`timescale 1ns/1ps
module tb_tt_um_islam_ihfaz_4_2_encoder;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  tt_um_islam_ihfaz_4_2_encoder #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pins seen at each edge, delayed by the synchronizer depth,
  // and a run length of identical candidates.
  logic [7:0] pin_q[$];
  logic [3:0] m_prev;
  int         m_run;
  logic       m_valid, m_strobe, m_multi;
  logic [1:0] m_code;
  logic [2:0] m_cnt;

  // Returns {none, code[1:0], multi}.
  function automatic logic [3:0] decode(input logic [7:0] p);
    int hi = -1;
    int n  = 0;
    if (p[4]) return 4'b1000;
    for (int i = 0; i < 4; i++) if (!p[i]) begin hi = i; n++; end
    if (hi < 0) return 4'b1000;
    return {1'b0, 2'(hi), (n > 1) ? 1'b1 : 1'b0};
  endfunction

  task automatic model_reset();
    pin_q.delete();
    for (int i = 0; i < SYNC_STAGES; i++) pin_q.push_back(8'h1F);
    m_prev = 4'b1000; m_run = 1;
    m_valid = 0; m_strobe = 0; m_multi = 0; m_code = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [3:0] c;
    c = decode(pin_q.pop_front());
    pin_q.push_back(ui_in);
    if (c == m_prev) m_run++; else m_run = 1;
    m_prev   = c;
    m_strobe = 0;
    if (m_run >= STABLE_CYCLES) begin
      if (!c[3] && (!m_valid || c[2:0] != {m_code, m_multi})) begin
        m_code = c[2:1]; m_multi = c[0]; m_valid = 1; m_strobe = 1; m_cnt = m_cnt + 3'd1;
      end else if (c[3] && m_valid) begin
        m_code = 0; m_multi = 0; m_valid = 0;
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    return {m_cnt, m_multi, m_strobe, m_valid, m_code};
  endfunction

  task automatic step(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      ui_in = v;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_eq("model", uo_out, model_out());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ui_in = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_hold", uo_out, 8'h00);
    end
    model_reset();
    ui_in = 8'h1F;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // Reset and idle
    do_reset();
    step(8'h1F, 6);
    check_eq("idle", uo_out, 8'h00);

    // Single request on line 2
    step(8'h0B, 5);
    check_eq("single_e5", uo_out, 8'h00);
    step(8'h0B, 1);
    check_eq("single_e6", uo_out, 8'h2E);
    step(8'h0B, 1);
    check_eq("single_e7", uo_out, 8'h26);

    // Lines 3 and 0 together: highest wins, conflict flagged
    step(8'h06, 6);
    check_eq("prio_e6", uo_out, 8'h5F);
    step(8'h06, 1);
    check_eq("prio_e7", uo_out, 8'h57);

    // Release to NONE, then a short glitch that must not commit
    step(8'h0F, 6);
    check_eq("release_none", uo_out, 8'h40);
    for (int i = 0; i < 3; i++) begin
      step(8'h0D, 1);
      check_eq("glitch", uo_out, 8'h40);
    end
    for (int i = 0; i < 8; i++) begin
      step(8'h0F, 1);
      check_eq("glitch", uo_out, 8'h40);
    end

    // Enable deasserted releases the committed code without strobe
    step(8'h0B, 6);
    check_eq("enable_commit", uo_out, 8'h6E);
    step(8'h0B, 2);
    step(8'h1B, 5);
    check_eq("disable_e5", uo_out, 8'h66);
    step(8'h1B, 1);
    check_eq("disable_e6", uo_out, 8'h60);

    // Counter wrap over 9 commit/release pairs from reset
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(8'h0E, 6);
      step(8'h0F, 6);
    end
    check_eq("wrap", uo_out, 8'h20);

    // Asynchronous reset while counting
    step(8'h0E, 3);
    check_eq("pre_reset", uo_out, 8'h20);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", uo_out, 8'h00);
    @(negedge clk);
    model_reset();
    ui_in = 8'h1F;
    rst_n = 1'b1;

    // Randomized holds of mostly-enabled request patterns
    for (int k = 0; k < 60; k++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) v[4] = 1'b0;
      step(v, $urandom_range(1, 8));
      if (k == 30) do_reset();
    end

    check_eq("uio_out", uio_out, 8'h00);
    check_eq("uio_oe", uio_oe, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
